// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one request at a time, performs a
// read-modify-write for sub-word stores, and returns an extended load result.
module lsu_ctrl #(
    parameter int MEM_WORDS     = 10,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic [31:0] data,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] mem_data,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; resp_valid stays high with stable payload until resp_ready.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        store_q, store_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        resp_valid_q, resp_valid_d;

    logic        req_err;
    logic        last_cycle;
    logic [4:0]  lane_shift;
    logic [31:0] lane_mask;
    logic [31:0] lane;
    logic [31:0] merged;
    logic [31:0] extracted;

    assign req_err = (req_size == 2'b11)
                  || (req_size == SZ_HALF && req_addr[0])
                  || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                  || ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

    assign last_cycle = (cnt_q == 4'(ACCESS_CYCLES - 1));

    // Big-endian lanes: byte offset 0 sits in the top byte of the word.
    always_comb begin
        lane_shift = 5'd0;
        lane_mask  = 32'hFFFF_FFFF;
        if (size_q == SZ_BYTE) begin
            lane_shift = {2'd3 - addr_q[1:0], 3'b000};
            lane_mask  = 32'h0000_00FF << lane_shift;
        end else if (size_q == SZ_HALF) begin
            lane_shift = addr_q[1] ? 5'd0 : 5'd16;
            lane_mask  = 32'h0000_FFFF << lane_shift;
        end
    end

    assign merged = (mem_data & ~lane_mask) | ((data_q << lane_shift) & lane_mask);
    assign lane   = mem_data >> lane_shift;

    always_comb begin
        extracted = mem_data;
        case (size_q)
            SZ_BYTE: extracted = uns_q ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            SZ_HALF: extracted = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: extracted = mem_data;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        store_d      = store_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        data_d       = data_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d = req_store;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    data_d  = req_wdata;
                    rdata_d = 32'h0;
                    err_d   = req_err;
                    cnt_d   = 4'd0;
                    if (req_err)
                        state_d = RESP;
                    else if (req_store && req_size != SZ_WORD)
                        state_d = RMW_RD;
                    else
                        state_d = ACCESS;
                end
            end
            RMW_RD: begin
                if (last_cycle) begin
                    data_d  = merged;
                    cnt_d   = 4'd0;
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ACCESS: begin
                if (last_cycle) begin
                    if (!store_q)
                        rdata_d = extracted;
                    cnt_d   = 4'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                // resp_valid rises one cycle after entering RESP.
                resp_valid_d = 1'b1;
                if (resp_valid_q && resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            store_q      <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= 32'h0;
            data_q       <= 32'h0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            store_q      <= store_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_valid_q ? rdata_q : 32'h0;
    assign resp_err   = resp_valid_q & err_q;
    assign memRead    = (state_q == RMW_RD) || (state_q == ACCESS && !store_q);
    assign memWrite   = (state_q == ACCESS) && store_q;
    assign address    = (state_q == RMW_RD || state_q == ACCESS) ? {2'b00, addr_q[31:2]} : 32'h0;
    assign data       = memWrite ? data_q : 32'h0;
    assign dbg_state  = state_q;

endmodule
